// File: rtl/misc_pkg.sv
// ---------------------------------------------------------------------------
// misc_pkg: shared packet, result and FSM types for mult_feeder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package misc_pkg;

  localparam int ARG_W = 16;
  localparam int RES_W = 32;

  typedef struct packed {
    logic [ARG_W-1:0] arg_a;
    logic             arg_a_parity;
    logic [ARG_W-1:0] arg_b;
    logic             arg_b_parity;
  } t_data_packet;

  typedef struct packed {
    logic [RES_W-1:0] mult_res;
    logic             result_par;
    logic             par_error;
  } t_s_output_vect;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RES = 2'd2
  } t_feeder_state;

  function automatic logic even_parity32(input logic [RES_W-1:0] v);
    return ^v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_feeder_fifo.sv
// ---------------------------------------------------------------------------
// mult_feeder_fifo: synchronous FIFO, power-of-two depth, first-word read. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_feeder_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

`default_nettype wire

// File: rtl/mult_feeder.sv
// ---------------------------------------------------------------------------
// mult_feeder: FIFO-buffered command feeder for a parity-checked multiplier. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_feeder
  import misc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  t_data_packet     in_data,
  output logic [ARG_W-1:0] mult_arg_a,
  output logic [ARG_W-1:0] mult_arg_b,
  output logic             mult_arg_a_parity,
  output logic             mult_arg_b_parity,
  output logic             mult_req,
  input  logic             mult_ack,
  input  logic [RES_W-1:0] mult_result,
  input  logic             mult_result_parity,
  input  logic             mult_result_rdy,
  input  logic             mult_arg_parity_error,
  output logic             out_valid,
  output t_s_output_vect   out_data,
  output logic             out_res_par_bad,
  output logic             timeout,
  output logic             busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  t_feeder_state state;
  t_feeder_state state_nxt;
  t_data_packet  head;
  t_data_packet  args;
  logic [CNT_W-1:0] cnt;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic done;
  logic expire;
  logic last_cycle;

  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;

  mult_feeder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(t_data_packet))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign last_cycle = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A result arriving on the final allowed cycle wins over the timeout.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (last_cycle) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end else if (mult_ack) begin
          state_nxt = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (mult_result_rdy) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (last_cycle) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      args            <= '0;
      cnt             <= '0;
      out_valid       <= 1'b0;
      out_data        <= '0;
      out_res_par_bad <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      if (pop) begin
        args <= head;
        cnt  <= '0;
      end else if (state != IDLE) begin
        cnt  <= cnt + 1'b1;
      end
      out_valid       <= done;
      timeout         <= expire;
      out_res_par_bad <= done & ~mult_arg_parity_error &
                         (even_parity32(mult_result) != mult_result_parity);
      if (done) begin
        out_data.mult_res   <= mult_result;
        out_data.result_par <= mult_result_parity;
        out_data.par_error  <= mult_arg_parity_error;
      end
    end
  end

  assign mult_req          = (state == REQ);
  assign busy              = (state != IDLE) | ~fifo_empty;
  assign mult_arg_a        = args.arg_a;
  assign mult_arg_b        = args.arg_b;
  assign mult_arg_a_parity = args.arg_a_parity;
  assign mult_arg_b_parity = args.arg_b_parity;

endmodule

`default_nettype wire

// File: tb/tb_mult_feeder.sv
// ---------------------------------------------------------------------------
// tb_mult_feeder: randomized bench with a behavioural multiplier and scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mult_feeder;
  import misc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  t_data_packet in_data = '0;
  logic [15:0] mult_arg_a, mult_arg_b;
  logic mult_arg_a_parity, mult_arg_b_parity;
  logic mult_req;
  logic mult_ack = 1'b0;
  logic [31:0] mult_result = '0;
  logic mult_result_parity = 1'b0;
  logic mult_result_rdy = 1'b0;
  logic mult_arg_parity_error = 1'b0;
  logic out_valid;
  t_s_output_vect out_data;
  logic out_res_par_bad;
  logic timeout;
  logic busy;

  mult_feeder dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_data               (in_data),
    .mult_arg_a            (mult_arg_a),
    .mult_arg_b            (mult_arg_b),
    .mult_arg_a_parity     (mult_arg_a_parity),
    .mult_arg_b_parity     (mult_arg_b_parity),
    .mult_req              (mult_req),
    .mult_ack              (mult_ack),
    .mult_result           (mult_result),
    .mult_result_parity    (mult_result_parity),
    .mult_result_rdy       (mult_result_rdy),
    .mult_arg_parity_error (mult_arg_parity_error),
    .out_valid             (out_valid),
    .out_data              (out_data),
    .out_res_par_bad       (out_res_par_bad),
    .timeout               (timeout),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        par;
    logic        perr;
    logic        bad;
  } t_exp;

  int n_checks = 0;
  int n_errors = 0;
  t_data_packet pending[$];
  t_exp         exp_q[$];
  int  out_cnt  = 0;
  logic last_bad = 1'b0;
  t_s_output_vect last_out = '0;

  bit fixed_dly = 1'b0;
  int ack_dly   = 0;
  int rdy_dly   = 0;
  bit never_ack = 1'b0;
  bit stall     = 1'b0;
  bit force_res = 1'b0;
  bit saw_reset = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic t_data_packet mk_pkt(input logic [15:0] a, input logic [15:0] b,
                                          input bit flip_a, input bit flip_b);
    t_data_packet p;
    p.arg_a        = a;
    p.arg_b        = b;
    p.arg_a_parity = (^a) ^ flip_a;
    p.arg_b_parity = (^b) ^ flip_b;
    return p;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_pkt(input t_data_packet p);
    int n = 0;
    in_data  = p;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("push_accept_wait", 64'(n < 500), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    if (n < 500) pending.push_back(p);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0 || pending.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_wait", 64'(n < 3000), 64'(1));
    repeat (4) @(negedge clk);
  endtask

  always @(negedge rst_n) saw_reset = 1'b1;

  // Behavioural multiplier: checks operand order, handshakes, returns a*b.
  initial begin
    t_data_packet ep;
    logic signed [15:0] sa, sb;
    int ia, ib, ad, rd, n;
    t_exp e;
    forever begin
      @(negedge clk);
      if (rst_n && mult_req) begin
        saw_reset = 1'b0;
        if (pending.size() == 0) begin
          check("req_without_packet", 64'(1), 64'(0));
          ep = '0;
        end else begin
          ep = pending.pop_front();
        end
        check("arg_a", 64'(mult_arg_a), 64'(ep.arg_a));
        check("arg_b", 64'(mult_arg_b), 64'(ep.arg_b));
        check("arg_a_par", 64'(mult_arg_a_parity), 64'(ep.arg_a_parity));
        check("arg_b_par", 64'(mult_arg_b_parity), 64'(ep.arg_b_parity));
        if (never_ack) begin
          n = 0;
          while (mult_req && n < 1000) begin
            @(negedge clk);
            n++;
          end
        end else begin
          while (stall) @(negedge clk);
          ad = fixed_dly ? ack_dly : int'($urandom_range(0, 4));
          rd = fixed_dly ? rdy_dly : int'($urandom_range(0, 4));
          repeat (ad) @(negedge clk);
          mult_ack = 1'b1;
          @(negedge clk);
          mult_ack = 1'b0;
          repeat (rd) @(negedge clk);
          sa = ep.arg_a;
          sb = ep.arg_b;
          ia = sa;
          ib = sb;
          if (force_res) begin
            e.res  = 32'h0000_0001;
            e.par  = 1'b0;
            e.perr = 1'b0;
          end else begin
            e.res  = 32'(ia * ib);
            e.par  = ^e.res;
            e.perr = ((^ep.arg_a) != ep.arg_a_parity) || ((^ep.arg_b) != ep.arg_b_parity);
          end
          e.bad = e.perr ? 1'b0 : ((^e.res) != e.par);
          mult_result           = e.res;
          mult_result_parity    = e.par;
          mult_arg_parity_error = e.perr;
          mult_result_rdy       = 1'b1;
          if (!saw_reset) exp_q.push_back(e);
          @(negedge clk);
          mult_result_rdy = 1'b0;
        end
      end
    end
  end

  // Output monitor / scoreboard.
  initial begin
    t_exp e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_out = '0;
      end else if (out_valid) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("out_mult_res", 64'(out_data.mult_res), 64'(e.res));
          check("out_result_par", 64'(out_data.result_par), 64'(e.par));
          check("out_par_error", 64'(out_data.par_error), 64'(e.perr));
          check("out_res_par_bad", 64'(out_res_par_bad), 64'(e.bad));
        end
        last_out = out_data;
        last_bad = out_res_par_bad;
      end else begin
        check("out_data_hold", 64'(out_data), 64'(last_out));
      end
    end
  end

  initial begin
    int n, base;
    t_data_packet p;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_mult_req", 64'(mult_req), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_timeout", 64'(timeout), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_arg_a", 64'(mult_arg_a), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 3 * -2 with clean parities.
    fixed_dly = 1'b1; ack_dly = 1; rdy_dly = 3;
    base = out_cnt;
    push_pkt(mk_pkt(16'd3, 16'hFFFE, 1'b0, 1'b0));
    check("req_latency_before", 64'(mult_req), 64'(0));
    @(negedge clk);
    check("req_latency_after", 64'(mult_req), 64'(1));
    wait_idle();
    check("t1_out_count", 64'(out_cnt - base), 64'(1));
    check("t1_mult_res", 64'(out_data.mult_res), 64'h0000_0000_FFFF_FFFA);
    check("t1_par_error", 64'(out_data.par_error), 64'(0));
    check("t1_bad", 64'(last_bad), 64'(0));

    // Wrong a parity: multiplier flags an argument parity error.
    push_pkt(mk_pkt(16'd1, 16'd5, 1'b1, 1'b0));
    wait_idle();
    check("t2_par_error", 64'(out_data.par_error), 64'(1));
    check("t2_bad", 64'(last_bad), 64'(0));

    // Result 1 with parity 0 is inconsistent.
    force_res = 1'b1;
    push_pkt(mk_pkt(16'd7, 16'd9, 1'b0, 1'b0));
    wait_idle();
    force_res = 1'b0;
    check("t3_bad", 64'(last_bad), 64'(1));
    check("t3_mult_res", 64'(out_data.mult_res), 64'(1));

    // Stalled multiplier: one command held in REQ, four fill the FIFO.
    stall = 1'b1; ack_dly = 0; rdy_dly = 1;
    base = out_cnt;
    push_pkt(mk_pkt(16'h0100, 16'h0002, 1'b0, 1'b0));
    for (int i = 1; i <= 4; i++) push_pkt(mk_pkt(16'(i * 3), 16'(i + 40), 1'b0, 1'b0));
    check("fifo_full_ready", 64'(in_ready), 64'(0));
    check("fifo_stall_req", 64'(mult_req), 64'(1));
    in_data  = mk_pkt(16'h1234, 16'h0010, 1'b0, 1'b0);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("fifo_full_hold", 64'(in_ready), 64'(0));
    stall = 1'b0;
    push_pkt(mk_pkt(16'h1234, 16'h0010, 1'b0, 1'b0));
    wait_idle();
    check("fifo_out_count", 64'(out_cnt - base), 64'(6));

    // Never acknowledged: abandon after 64 cycles.
    never_ack = 1'b1;
    base = out_cnt;
    push_pkt(mk_pkt(16'd11, 16'd12, 1'b0, 1'b0));
    @(negedge clk);
    check("to_req", 64'(mult_req), 64'(1));
    n = 0;
    while (!timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", 64'(n), 64'(64));
    check("to_req_drop", 64'(mult_req), 64'(0));
    check("to_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("to_pulse_end", 64'(timeout), 64'(0));
    never_ack = 1'b0;
    repeat (5) @(negedge clk);
    check("to_no_out", 64'(out_cnt - base), 64'(0));

    // Reset while waiting for a result.
    ack_dly = 1; rdy_dly = 12;
    base = out_cnt;
    push_pkt(mk_pkt(16'd21, 16'd22, 1'b0, 1'b0));
    n = 0;
    while (!mult_req && n < 20) begin @(negedge clk); n++; end
    while (mult_req && n < 40) begin @(negedge clk); n++; end
    check("rs_reach_wait", 64'(n < 40), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rs_mult_req", 64'(mult_req), 64'(0));
    check("rs_busy", 64'(busy), 64'(0));
    check("rs_in_ready", 64'(in_ready), 64'(1));
    check("rs_out_data", 64'(out_data), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("rs_no_out", 64'(out_cnt - base), 64'(0));
    check("rs_idle", 64'(busy), 64'(0));

    // Randomized traffic with random delays and occasional bad parities.
    fixed_dly = 1'b0;
    base = out_cnt;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      p = mk_pkt(16'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0));
      push_pkt(p);
    end
    wait_idle();
    check("rand_out_count", 64'(out_cnt - base), 64'(40));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
